// File: rtl/pulse_transmitter_symbol_sequencer.sv
// pulse_transmitter_symbol_sequencer: steps a symbol buffer, loading and triggering a countdown timer per symbol
// Ports: clk/sys_rst_n clock and sync active-low reset; wr_en/wr_addr/wr_data symbol write ({level, dur_sel});
// dur0/dur1/psc0/psc1 timer values per dur_sel; symbol_count symbols per pass; loop_en, idle_level, start, stop;
// timer_done timer completion pulse; tim_trig/tim_duration/tim_prescaler timer load; pin_out level;
// busy, done, loop_pulse, symbol_idx status.
module pulse_transmitter_symbol_sequencer #(
    parameter int PRESCALER_WIDTH = 15,
    parameter int TIMER_WIDTH = 8,
    parameter int SYMBOL_DEPTH = 32,
    localparam int PW = $clog2(PRESCALER_WIDTH + 1),
    localparam int AW = $clog2(SYMBOL_DEPTH),
    localparam int CW = $clog2(SYMBOL_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [1:0]             wr_data,
    input  logic [TIMER_WIDTH-1:0] dur0,
    input  logic [TIMER_WIDTH-1:0] dur1,
    input  logic [PW-1:0]          psc0,
    input  logic [PW-1:0]          psc1,
    input  logic [CW-1:0]          symbol_count,
    input  logic                   loop_en,
    input  logic                   idle_level,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   timer_done,
    output logic                   tim_trig,
    output logic [TIMER_WIDTH-1:0] tim_duration,
    output logic [PW-1:0]          tim_prescaler,
    output logic                   pin_out,
    output logic                   busy,
    output logic                   done,
    output logic                   loop_pulse,
    output logic [AW-1:0]          symbol_idx
);
    typedef enum logic [1:0] {IDLE, LOAD, TRIG, WAIT} state_t;
    state_t state_q, state_d;
    logic [1:0] sym_q [SYMBOL_DEPTH];
    logic [CW-1:0] count_q, count_d, count_clamp;
    logic [AW-1:0] idx_q, idx_d;
    logic [TIMER_WIDTH-1:0] dur_q, dur_d;
    logic [PW-1:0] psc_q, psc_d;
    logic pin_q, pin_d, trig_q, trig_d, busy_q, busy_d, done_q, done_d, loop_q, loop_d;
    logic [1:0] sym;
    logic last;
    assign count_clamp = (symbol_count > CW'(SYMBOL_DEPTH)) ? CW'(SYMBOL_DEPTH) : symbol_count;
    assign sym = sym_q[idx_q];
    assign last = CW'(idx_q) + CW'(1) >= count_q;
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < SYMBOL_DEPTH; i++) sym_q[i] <= '0;
        end else if (wr_en) begin
            sym_q[wr_addr] <= wr_data;
        end
    end
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            dur_q   <= '0;
            psc_q   <= '0;
            pin_q   <= 1'b0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            psc_q   <= psc_d;
            pin_q   <= pin_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            loop_q  <= loop_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start && !stop && count_clamp != '0) ? LOAD : IDLE;
            LOAD:    state_d = stop ? IDLE : TRIG;
            TRIG:    state_d = stop ? IDLE : WAIT;
            default: state_d = stop ? IDLE : !timer_done ? WAIT : (last && !loop_en) ? IDLE : LOAD;
        endcase
    end
    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        psc_d   = psc_q;
        pin_d   = pin_q;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        loop_d  = 1'b0;
        busy_d  = state_d != IDLE;
        case (state_q)
            IDLE: begin
                pin_d = idle_level;
                if (state_d == LOAD) begin
                    idx_d   = '0;
                    count_d = count_clamp;
                end
            end
            LOAD: begin
                if (!stop) begin
                    pin_d  = sym[1];
                    dur_d  = sym[0] ? dur1 : dur0;
                    psc_d  = sym[0] ? psc1 : psc0;
                    trig_d = 1'b1;
                end
            end
            TRIG: ;
            default: begin
                // Loop wraps re-enter LOAD like any other symbol so the per-symbol overhead stays constant.
                if (!stop && timer_done) begin
                    idx_d  = (!last || !loop_en) ? (last ? idx_q : idx_q + AW'(1)) : '0;
                    loop_d = last && loop_en;
                    done_d = last && !loop_en;
                    pin_d  = (last && !loop_en) ? idle_level : pin_q;
                end
            end
        endcase
    end
    assign tim_trig      = trig_q;
    assign tim_duration  = dur_q;
    assign tim_prescaler = psc_q;
    assign pin_out       = pin_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign loop_pulse    = loop_q;
    assign symbol_idx    = idx_q;
endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// tb_pulse_transmitter_symbol_sequencer: self-checking bench with a countdown timer model and symbol scoreboard
module tb_pulse_transmitter_symbol_sequencer;
    logic clk = 1'b0, sys_rst_n = 1'b0, wr_en = 1'b0, loop_en = 1'b0, idle_level = 1'b1;
    logic start = 1'b0, stop = 1'b0, td_man = 1'b0, timer_done;
    logic [4:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic [7:0] dur0 = 8'd4, dur1 = 8'd3;
    logic [3:0] psc0 = 4'd0, psc1 = 4'd1;
    logic [5:0] symbol_count = '0;
    logic tim_trig, pin_out, busy, done, loop_pulse;
    logic [7:0] tim_duration;
    logic [3:0] tim_prescaler;
    logic [4:0] symbol_idx;
    pulse_transmitter_symbol_sequencer dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dur0(dur0), .dur1(dur1), .psc0(psc0), .psc1(psc1), .symbol_count(symbol_count),
        .loop_en(loop_en), .idle_level(idle_level), .start(start), .stop(stop), .timer_done(timer_done),
        .tim_trig(tim_trig), .tim_duration(tim_duration), .tim_prescaler(tim_prescaler), .pin_out(pin_out),
        .busy(busy), .done(done), .loop_pulse(loop_pulse), .symbol_idx(symbol_idx)
    );
    always #5 clk = ~clk;
    // Countdown timer model: on a trigger rising edge it counts duration*(prescaler+1) cycles, then pulses done.
    logic tp = 1'b0, tarm = 1'b0, tdone = 1'b0;
    int tleft = 0;
    always @(posedge clk) begin
        if (!sys_rst_n) begin
            tp <= 1'b0; tarm <= 1'b0; tdone <= 1'b0; tleft <= 0;
        end else begin
            tp <= tim_trig;
            tdone <= 1'b0;
            if (tim_trig && !tp) begin
                tarm <= 1'b1;
                tleft <= int'(tim_duration) * (int'(tim_prescaler) + 1);
            end else if (tarm) begin
                if (tleft <= 1) begin tdone <= 1'b1; tarm <= 1'b0; end
                else tleft <= tleft - 1;
            end
        end
    end
    assign timer_done = tdone | td_man;
    typedef struct { logic lv; logic [7:0] dur; logic [3:0] psc; logic [4:0] idx; int hold; } exp_t;
    typedef struct { logic [5:0] syms; logic [5:0] cnt; logic idle; logic [2:0] lv; logic [2:0] sel; int n; } vec_t;
    exp_t q[$];
    vec_t vecs[5];
    int checks = 0, errors = 0, ntrig = 0, ndone = 0, nloop = 0, cyc = 0, t_last = 0, hold_last = 0;
    bit pend = 0, trig_prev = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask
    // Expected hold from one trigger to the next: timer length (a zero length still takes one cycle) plus 3 cycles overhead.
    task automatic push_exp(input int idx, input logic lv, input logic sel);
        exp_t e;
        int len;
        len = sel ? int'(dur1) * (int'(psc1) + 1) : int'(dur0) * (int'(psc0) + 1);
        e.lv = lv; e.dur = sel ? dur1 : dur0; e.psc = sel ? psc1 : psc0; e.idx = 5'(idx);
        e.hold = (len == 0 ? 1 : len) + 3;
        q.push_back(e);
    endtask
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (tim_trig) chk("trig_single_cycle", 32'(trig_prev), 0);
        if (tim_trig && !trig_prev) begin
            ntrig++;
            if (pend) chk("symbol_hold", cyc - t_last, hold_last);
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_trig actual=idx%0d required=none", symbol_idx);
            end else begin
                e = q.pop_front();
                chk("sym_level", 32'(pin_out), 32'(e.lv));
                chk("sym_duration", 32'(tim_duration), 32'(e.dur));
                chk("sym_prescaler", 32'(tim_prescaler), 32'(e.psc));
                chk("sym_idx", 32'(symbol_idx), 32'(e.idx));
                t_last = cyc; hold_last = e.hold; pend = 1;
            end
        end
        if (done) begin
            ndone++;
            if (pend) chk("done_time", cyc - t_last, hold_last - 1);
            chk("done_pin_idle", 32'(pin_out), 32'(idle_level));
            chk("done_busy_low", 32'(busy), 0);
        end
        if (loop_pulse) nloop++;
        if (!busy) pend = 0;
        trig_prev = tim_trig;
    endtask
    task automatic wr(input int a, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask
    task automatic wait_done(input int budget, input bit clear_loop);
        int d0, l0, n;
        d0 = ndone; l0 = nloop; n = 0;
        while (ndone == d0 && n < budget) begin
            tick();
            n++;
            if (clear_loop && nloop > l0) loop_en = 1'b0;
        end
        chk("done_seen", 32'(ndone - d0), 1);
    endtask
    task automatic wait_trig(input int target, input int budget);
        int n;
        n = 0;
        while (ntrig < target && n < budget) begin tick(); n++; end
        chk("trig_reached", 32'(ntrig >= target), 1);
    endtask
    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 3; i++) wr(i, v.syms[2*i +: 2]);
        idle_level = v.idle; symbol_count = v.cnt;
        tick();
        for (int i = 0; i < v.n; i++) push_exp(i, v.lv[i], v.sel[i]);
    endtask
    task automatic kick();
        start = 1'b1;
        tick();
        chk("start_busy", 32'(busy), 1);
        chk("start_trig_low", 32'(tim_trig), 0);
        start = 1'b0;
    endtask
    task automatic run_vec(input vec_t v);
        int t0, d0;
        load_vec(v);
        t0 = ntrig; d0 = ndone;
        kick();
        wait_done(300, 0);
        chk("queue_drained", 32'(q.size()), 0);
        chk("trig_count", 32'(ntrig - t0), 32'(v.n));
        tick();
        chk("idle_pin", 32'(pin_out), 32'(v.idle));
        chk("idle_busy", 32'(busy), 0);
        chk("done_once", 32'(ndone - d0), 1);
    endtask
    initial begin
        int t0, d0, l0;
        vecs[0] = '{6'b11_01_10, 6'd3, 1'b0, 3'b101, 3'b110, 3};
        vecs[1] = '{6'b11_01_10, 6'd2, 1'b1, 3'b001, 3'b010, 2};
        vecs[2] = '{6'b11_00_00, 6'd3, 1'b1, 3'b100, 3'b100, 3};
        vecs[3] = '{6'b00_00_01, 6'd1, 1'b0, 3'b000, 3'b001, 1};
        vecs[4] = '{6'b10_11_00, 6'd3, 1'b1, 3'b110, 3'b010, 3};
        // Reset
        tick(); tick();
        chk("rst_pin", 32'(pin_out), 0);
        chk("rst_trig", 32'(tim_trig), 0);
        chk("rst_dur", 32'(tim_duration), 0);
        chk("rst_psc", 32'(tim_prescaler), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_loop", 32'(loop_pulse), 0);
        chk("rst_idx", 32'(symbol_idx), 0);
        sys_rst_n = 1'b1;
        tick();
        chk("post_rst_pin_idle", 32'(pin_out), 1);
        chk("post_rst_busy", 32'(busy), 0);
        // Zero count ignores start
        symbol_count = '0; start = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        chk("count0_busy", 32'(busy), 0);
        chk("count0_no_trig", 32'(ntrig), 0);
        // Table-driven single passes
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        // Zero-duration boundary
        dur0 = 8'd0;
        run_vec(vecs[2]);
        dur0 = 8'd4;
        // Looping: two passes then done
        load_vec(vecs[0]);
        for (int i = 0; i < 3; i++) push_exp(i, vecs[0].lv[i], vecs[0].sel[i]);
        loop_en = 1'b1; t0 = ntrig; l0 = nloop;
        kick();
        wait_done(300, 1);
        chk("loop_pulses", 32'(nloop - l0), 1);
        chk("loop_symbols", 32'(ntrig - t0), 6);
        chk("loop_queue", 32'(q.size()), 0);
        // Stop in WAIT of symbol 1, stale timer_done ignored, then replay
        load_vec(vecs[0]);
        t0 = ntrig; d0 = ndone;
        kick();
        wait_trig(t0 + 2, 100);
        tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_no_done", 32'(ndone - d0), 0);
        tick();
        chk("stop_pin_idle", 32'(pin_out), 0);
        q.delete();
        repeat (20) tick();
        chk("stale_done_ignored", 32'(ntrig - t0), 2);
        chk("stale_busy", 32'(busy), 0);
        chk("stale_no_done", 32'(ndone - d0), 0);
        run_vec(vecs[0]);
        // timer_done during TRIG is ignored
        load_vec(vecs[0]);
        t0 = ntrig;
        kick();
        tick();
        chk("in_trig", 32'(ntrig - t0), 1);
        td_man = 1'b1;
        tick();
        td_man = 1'b0;
        wait_done(300, 0);
        chk("trig_pulse_queue", 32'(q.size()), 0);
        // start held throughout a pass
        load_vec(vecs[0]);
        t0 = ntrig;
        start = 1'b1;
        wait_done(300, 0);
        start = 1'b0;
        tick();
        chk("held_start_trigs", 32'(ntrig - t0), 3);
        chk("held_start_idle", 32'(busy), 0);
        // start+stop together while busy and in IDLE
        load_vec(vecs[0]);
        t0 = ntrig;
        kick();
        wait_trig(t0 + 1, 50);
        start = 1'b1; stop = 1'b1;
        tick();
        chk("startstop_busy", 32'(busy), 0);
        chk("startstop_idx", 32'(symbol_idx), 0);
        repeat (5) tick();
        start = 1'b0; stop = 1'b0;
        q.delete();
        repeat (15) tick();
        chk("startstop_no_restart", 32'(ntrig - t0), 1);
        chk("startstop_idle", 32'(busy), 0);
        // Rewrite symbol 2 while symbol 0 transmits
        load_vec('{6'b11_01_10, 6'd3, 1'b0, 3'b000, 3'b000, 0});
        push_exp(0, 1'b1, 1'b0); push_exp(1, 1'b0, 1'b1); push_exp(2, 1'b0, 1'b0);
        t0 = ntrig;
        kick();
        wait_trig(t0 + 1, 50);
        wr(2, 2'b00);
        wait_done(300, 0);
        chk("rewrite_queue", 32'(q.size()), 0);
        // Count clamps to depth and wraps after index 31
        dur0 = 8'd1; psc0 = 4'd0;
        for (int i = 0; i < 32; i++) wr(i, {i[0], 1'b0});
        symbol_count = 6'd40; idle_level = 1'b0;
        for (int i = 0; i < 64; i++) push_exp(i % 32, i[0], 1'b0);
        loop_en = 1'b1; t0 = ntrig; l0 = nloop;
        tick();
        kick();
        wait_done(1000, 1);
        chk("clamp_symbols", 32'(ntrig - t0), 64);
        chk("clamp_loops", 32'(nloop - l0), 1);
        chk("clamp_queue", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_transmitter_symbol_sequencer.md
# pulse_transmitter_symbol_sequencer

Upstream control stage of the pulse transmitter. It steps through a small symbol buffer and drives the output pin level for each symbol. For every symbol it loads a duration and prescaler into the one-shot countdown timer, fires the timer trigger, and waits for the timer's completion pulse before advancing. It supports single-pass and looping transmission, and abort.

## Interface
- PRESCALER_WIDTH, 15, width parameter shared with the countdown timer; prescaler ports are $clog2(PRESCALER_WIDTH+1) bits.
- TIMER_WIDTH, 8, duration width.
- SYMBOL_DEPTH, 32, number of symbol entries; AW = $clog2(SYMBOL_DEPTH), CW = $clog2(SYMBOL_DEPTH+1).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- wr_en / wr_addr / wr_data  in  1 / AW / 2  symbol write port; wr_data = {level, dur_sel}.
- dur0, dur1  in  TIMER_WIDTH  duration for dur_sel 0 / 1.
- psc0, psc1  in  PW  prescaler for dur_sel 0 / 1.
- symbol_count  in  CW  symbols per pass.
- loop_en  in  1  restart at symbol 0 after the last symbol.
- idle_level  in  1  pin level when not transmitting.
- start, stop  in  1  level-sampled commands.
- timer_done  in  1  one-cycle completion pulse from the countdown timer.
- tim_trig  out  1  timer trigger; the timer acts on its rising edge.
- tim_duration / tim_prescaler  out  TIMER_WIDTH / PW  timer load values.
- pin_out  out  1  transmitted level.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at normal end of a non-looping pass.
- loop_pulse  out  1  one-cycle pulse at each loop wrap.
- symbol_idx  out  AW  index of the current symbol.

## Operation
- Symbol buffer:
  - SYMBOL_DEPTH x 2-bit registers, all cleared by reset.
  - Writes take one cycle and are allowed at any time.
  - A symbol is read combinationally at symbol_idx in LOAD, so a write to a not-yet-fetched entry takes effect in the current pass.
- symbol_count is latched at start; values above SYMBOL_DEPTH clamp to SYMBOL_DEPTH.
- loop_en is sampled live at the end of each pass.
- FSM states: IDLE, LOAD, TRIG, WAIT.
  - IDLE: pin_out <= idle_level. If start=1, stop=0 and the latched count is nonzero: symbol_idx <= 0, go to LOAD. With count 0, start is ignored.
  - LOAD: pin_out <= level; tim_duration/tim_prescaler <= dur_sel ? dur1/psc1 : dur0/psc0; tim_trig <= 1; go to TRIG.
  - TRIG: tim_trig <= 0; go to WAIT.
  - WAIT, on timer_done:
    - If symbol_idx < count-1: symbol_idx++, go to LOAD.
    - Else if loop_en: symbol_idx <= 0, loop_pulse, go to LOAD.
    - Else: done, go to IDLE.
- timer_done is honoured only in WAIT and ignored in all other states. A stale pulse after stop, or a pulse arriving while in TRIG, must not advance the FSM.
- stop=1 in any non-IDLE state:
  - Next state is IDLE, tim_trig <= 0, and done is not pulsed.
  - pin_out returns to idle_level on the following IDLE cycle.
  - If stop and start are asserted together, stop wins.
- start while busy is ignored.
- Duration and prescaler values are passed through unchanged. A zero duration is legal; its timing is set by the timer.

## Timing
- Reset values: pin_out=0, tim_trig=0, tim_duration=0, tim_prescaler=0, busy=0, done=0, loop_pulse=0, symbol_idx=0, state IDLE.
- pin_out follows idle_level starting from the first cycle after reset.
- All outputs are registered.
- Start: start sampled at edge e0 → busy=1 after e0 → pin_out, tim_trig=1 and load values updated at e1 → tim_trig=0 at e2.
- Per symbol: timer_done sampled at edge k → pin_out and next tim_trig rise at k+1. The fixed inter-symbol overhead is identical for every symbol, including loop wraps.
- tim_trig is high for exactly one cycle and low for at least one cycle between triggers. This guarantees the timer sees a rising edge for every symbol.
- done (or loop_pulse) is asserted in the cycle after the final timer_done.
- Non-looping end: busy falls and pin_out returns to idle_level in the same cycle done is asserted.

## Test plan
- Reset with idle_level=1 → all outputs 0 in the reset cycle, then pin_out=1 with busy=0. A start with symbol_count=0 keeps busy=0 and tim_trig never rises.
- Write symbols {1,0},{0,1},{1,1}; set dur0=4, psc0=0, dur1=3, psc1=1, count=3, loop_en=0; start with the real countdown timer → pin_out 1,0,1 with hold times in ratio 4:6:6 plus a constant overhead. Exactly three single-cycle tim_trig pulses; done pulses once; pin_out returns to idle_level.
- Same program with loop_en=1 for 2 passes, then clear loop_en → loop_pulse once, 6 symbols in total, then done.
- stop asserted in WAIT of symbol 1 → IDLE on the next edge with no done. The timer's late timer_done is ignored; start then replays from symbol 0.
- start held during busy, and start+stop in the same cycle → no restart, symbol_idx is not disturbed, and the FSM stays in (or enters) IDLE.
- Rewrite symbol 2 while symbol 0 is transmitting → the new level appears on pin_out for symbol 2. symbol_count=40 with SYMBOL_DEPTH=32 → symbol_idx wraps after index 31.
